// File: rtl/dce_loopback_multi.sv
// Multi-channel 8N1 UART DCE loopback: per-channel RX deserialiser, loopback FIFO
// with RTS/CTS flow control, TX serialiser, and saturating error counters.
module dce_loopback_multi #(
  parameter int NUM_CH     = 2,
  parameter int BAUD_DIV   = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CTS_MARGIN = 2,
  parameter int CROSS_MODE = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     txd,
  output logic [NUM_CH-1:0]     rxd,
  input  logic [NUM_CH-1:0]     rts,
  output logic [NUM_CH-1:0]     cts,
  output logic [32*NUM_CH-1:0]  dbr,
  output logic [8*NUM_CH-1:0]   overrun_cnt,
  output logic [8*NUM_CH-1:0]   frame_err_cnt
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [BW-1:0] FULL_BIT  = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_BIT  = BW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CTS_LIMIT = CW'(FIFO_DEPTH - CTS_MARGIN);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

  logic [NUM_CH-1:0]    rx_push_all;
  logic [8*NUM_CH-1:0]  rx_byte_all;
  logic [CW*NUM_CH-1:0] count_all;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    // SRC: RX channel feeding this channel's FIFO; DST: FIFO this channel's RX feeds.
    localparam int SRC = (CROSS_MODE != 0) ? (ch + NUM_CH - 1) % NUM_CH : ch;
    localparam int DST = (CROSS_MODE != 0) ? (ch + 1) % NUM_CH : ch;

    logic          sync1, sync2, rx_prev;
    uart_state_t   rx_state, rx_state_n;
    logic [BW-1:0] rx_cnt, rx_cnt_n;
    logic [2:0]    rx_idx, rx_idx_n;
    logic [7:0]    rx_sr, rx_sr_n;
    logic          rx_done, rx_bad, rx_push;
    logic [7:0]    ferr;

    always_ff @(posedge clock) begin
      if (reset) begin
        sync1   <= 1'b1;
        sync2   <= 1'b1;
        rx_prev <= 1'b1;
      end else begin
        sync1   <= txd[ch];
        sync2   <= sync1;
        rx_prev <= sync2;
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        rx_state <= IDLE;
        rx_cnt   <= '0;
        rx_idx   <= '0;
        rx_sr    <= '0;
        rx_push  <= 1'b0;
        ferr     <= '0;
      end else begin
        rx_state <= rx_state_n;
        rx_cnt   <= rx_cnt_n;
        rx_idx   <= rx_idx_n;
        rx_sr    <= rx_sr_n;
        rx_push  <= rx_done;
        if (rx_bad && ferr != 8'hFF) ferr <= ferr + 8'd1;
      end
    end

    always_comb begin
      rx_state_n = rx_state;
      rx_cnt_n   = rx_cnt;
      rx_idx_n   = rx_idx;
      rx_sr_n    = rx_sr;
      rx_done    = 1'b0;
      rx_bad     = 1'b0;
      case (rx_state)
        IDLE: begin
          if (rx_prev && !sync2) begin
            rx_cnt_n   = HALF_BIT;
            rx_state_n = START;
          end
        end
        START: begin
          if (rx_cnt == '0) begin
            if (!sync2) begin
              rx_cnt_n   = FULL_BIT;
              rx_idx_n   = '0;
              rx_state_n = DATA;
            end else begin
              rx_state_n = IDLE;
            end
          end else begin
            rx_cnt_n = rx_cnt - 1'b1;
          end
        end
        DATA: begin
          if (rx_cnt == '0) begin
            rx_sr_n  = {sync2, rx_sr[7:1]};
            rx_cnt_n = FULL_BIT;
            if (rx_idx == 3'd7) rx_state_n = STOP;
            else                rx_idx_n   = rx_idx + 3'd1;
          end else begin
            rx_cnt_n = rx_cnt - 1'b1;
          end
        end
        STOP: begin
          if (rx_cnt == '0) begin
            rx_done    = sync2;
            rx_bad     = !sync2;
            rx_state_n = IDLE;
          end else begin
            rx_cnt_n = rx_cnt - 1'b1;
          end
        end
        default: rx_state_n = IDLE;
      endcase
    end

    assign rx_push_all[ch]         = rx_push;
    assign rx_byte_all[8*ch +: 8]  = rx_sr;
    assign frame_err_cnt[8*ch +: 8] = ferr;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [7:0]    ovr;
    logic          avail, push, full, wr_en, tx_pop, cts_r;

    assign push  = rx_push_all[SRC];
    assign full  = (count == DEPTH_C);
    assign wr_en = push && !full;

    always_ff @(posedge clock) begin
      if (wr_en) mem[wr_ptr] <= rx_byte_all[8*SRC +: 8];
    end

    // avail is a registered copy of non-empty; it only gates IDLE, where it is never stale.
    always_ff @(posedge clock) begin
      if (reset) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        ovr    <= '0;
        avail  <= 1'b0;
        cts_r  <= 1'b0;
      end else begin
        if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
        if (tx_pop) rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(wr_en) - CW'(tx_pop);
        if (push && full && ovr != 8'hFF) ovr <= ovr + 8'd1;
        avail <= (count != '0);
        cts_r <= (count_all[CW*DST +: CW] < CTS_LIMIT);
      end
    end

    assign count_all[CW*ch +: CW]  = count;
    assign overrun_cnt[8*ch +: 8]  = ovr;
    assign cts[ch]                 = cts_r;
    assign dbr[32*ch +: 32]        = 32'(BAUD_DIV);

    uart_state_t   tx_state, tx_state_n;
    logic [BW-1:0] tx_cnt, tx_cnt_n;
    logic [2:0]    tx_idx, tx_idx_n;
    logic [7:0]    tx_sr, tx_sr_n;
    logic          rxd_r, rxd_n;

    always_ff @(posedge clock) begin
      if (reset) begin
        tx_state <= IDLE;
        tx_cnt   <= '0;
        tx_idx   <= '0;
        tx_sr    <= '0;
        rxd_r    <= 1'b1;
      end else begin
        tx_state <= tx_state_n;
        tx_cnt   <= tx_cnt_n;
        tx_idx   <= tx_idx_n;
        tx_sr    <= tx_sr_n;
        rxd_r    <= rxd_n;
      end
    end

    always_comb begin
      tx_state_n = tx_state;
      tx_cnt_n   = tx_cnt;
      tx_idx_n   = tx_idx;
      tx_sr_n    = tx_sr;
      tx_pop     = 1'b0;
      rxd_n      = 1'b1;
      case (tx_state)
        IDLE: begin
          if (avail && rts[ch]) begin
            tx_pop     = 1'b1;
            tx_sr_n    = mem[rd_ptr];
            tx_cnt_n   = FULL_BIT;
            tx_state_n = START;
          end
        end
        START: begin
          if (tx_cnt == '0) begin
            tx_cnt_n   = FULL_BIT;
            tx_idx_n   = '0;
            tx_state_n = DATA;
          end else begin
            tx_cnt_n = tx_cnt - 1'b1;
          end
        end
        DATA: begin
          if (tx_cnt == '0) begin
            tx_cnt_n = FULL_BIT;
            if (tx_idx == 3'd7) begin
              tx_state_n = STOP;
            end else begin
              tx_idx_n = tx_idx + 3'd1;
              tx_sr_n  = {1'b0, tx_sr[7:1]};
            end
          end else begin
            tx_cnt_n = tx_cnt - 1'b1;
          end
        end
        STOP: begin
          if (tx_cnt == '0) tx_state_n = IDLE;
          else              tx_cnt_n   = tx_cnt - 1'b1;
        end
        default: tx_state_n = IDLE;
      endcase
      case (tx_state_n)
        START:   rxd_n = 1'b0;
        DATA:    rxd_n = tx_sr_n[0];
        default: rxd_n = 1'b1;
      endcase
    end

    assign rxd[ch] = rxd_r;
  end

endmodule

// File: tb/tb_dce_loopback_multi.sv
// Directed self-checking bench for dce_loopback_multi: one straight-loopback instance
// and one cross-routed instance, driven as a UART transactor would.
module tb_dce_loopback_multi;

  localparam int BD = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  txd, rxd, rts, cts;
  logic [63:0] dbr;
  logic [15:0] ovr, ferr;
  logic [1:0]  txd_x, rxd_x, rts_x, cts_x;
  logic [63:0] dbr_x;
  logic [15:0] ovr_x, ferr_x;

  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  dce_loopback_multi #(.NUM_CH(2), .BAUD_DIV(BD), .FIFO_DEPTH(8), .CTS_MARGIN(2), .CROSS_MODE(0)) dut (
    .clock(clock), .reset(reset), .txd(txd), .rxd(rxd), .rts(rts), .cts(cts),
    .dbr(dbr), .overrun_cnt(ovr), .frame_err_cnt(ferr)
  );

  dce_loopback_multi #(.NUM_CH(2), .BAUD_DIV(BD), .FIFO_DEPTH(8), .CTS_MARGIN(2), .CROSS_MODE(1)) dut_x (
    .clock(clock), .reset(reset), .txd(txd_x), .rxd(rxd_x), .rts(rts_x), .cts(cts_x),
    .dbr(dbr_x), .overrun_cnt(ovr_x), .frame_err_cnt(ferr_x)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic setTxd(input bit x, input int ch, input logic v);
    if (x) txd_x[ch] = v;
    else   txd[ch]   = v;
  endtask

  function automatic logic lineOf(input bit x, input int ch);
    return x ? rxd_x[ch] : rxd[ch];
  endfunction

  task automatic applyStimulus(input bit x, input int ch, input logic [7:0] data, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      setTxd(x, ch, frame[b]);
      repeat (BD) @(negedge clock);
    end
    setTxd(x, ch, 1'b1);
    repeat (4) @(negedge clock);
  endtask

  // Waits for a start bit, then samples every bit at its middle.
  task automatic expectFrame(input bit x, input int ch, input logic [7:0] data, input string tag);
    int waited;
    logic [9:0] got;
    logic seen;
    waited = 0;
    got = '0;
    while (lineOf(x, ch) !== 1'b0 && waited < 2000) begin
      @(negedge clock);
      waited++;
    end
    seen = (lineOf(x, ch) === 1'b0);
    checkOutput({tag, "_start"}, 32'(seen), 32'd1);
    if (seen) begin
      repeat (BD/2) @(negedge clock);
      got[0] = lineOf(x, ch);
      for (int b = 1; b < 10; b++) begin
        repeat (BD) @(negedge clock);
        got[b] = lineOf(x, ch);
      end
      checkOutput(tag, 32'(got), 32'({1'b1, data, 1'b0}));
    end
  endtask

  task automatic expectIdle(input bit x, input int ch, input int cycles, input string tag);
    int lows;
    lows = 0;
    repeat (cycles) begin
      @(negedge clock);
      if (lineOf(x, ch) !== 1'b1) lows++;
    end
    checkOutput(tag, 32'(lows), 32'd0);
  endtask

  initial begin
    txd = 2'b11; rts = 2'b11; txd_x = 2'b11; rts_x = 2'b11;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checkOutput("reset_rxd", 32'(rxd), 32'h3);
    checkOutput("reset_cts", 32'(cts), 32'h0);
    checkOutput("reset_ovr", 32'(ovr), 32'h0);
    checkOutput("reset_ferr", 32'(ferr), 32'h0);
    checkOutput("dbr0", dbr[31:0], 32'd16);
    checkOutput("dbr1", dbr[63:32], 32'd16);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("cts_after_reset", 32'(cts), 32'h3);

    fork
      applyStimulus(1'b0, 0, 8'hA5, 1'b1);
      expectFrame(1'b0, 0, 8'hA5, "echo_a5");
      expectIdle(1'b0, 1, 400, "rxd1_idle");
    join
    checkOutput("ovr_after_a5", 32'(ovr), 32'h0);
    checkOutput("ferr_after_a5", 32'(ferr), 32'h0);

    // Fill FIFO 0 with the transactor not ready.
    rts[0] = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          applyStimulus(1'b0, 0, 8'(i), 1'b1);
          if (i == 4) checkOutput("cts_after_5", 32'(cts[0]), 32'd1);
          if (i == 5) checkOutput("cts_after_6", 32'(cts[0]), 32'd0);
        end
      end
      expectIdle(1'b0, 0, 1300, "no_tx_rts_low");
    join
    applyStimulus(1'b0, 0, 8'h08, 1'b1);
    applyStimulus(1'b0, 0, 8'h09, 1'b1);
    checkOutput("overrun0", 32'(ovr[7:0]), 32'd2);
    checkOutput("overrun1", 32'(ovr[15:8]), 32'd0);
    checkOutput("cts_full", 32'(cts[0]), 32'd0);
    rts[0] = 1'b1;
    for (int i = 0; i < 8; i++) expectFrame(1'b0, 0, 8'(i), "drain");
    checkOutput("cts_restored", 32'(cts[0]), 32'd1);
    fork
      applyStimulus(1'b0, 0, 8'h10, 1'b1);
      expectFrame(1'b0, 0, 8'h10, "echo_10");
    join

    fork
      applyStimulus(1'b0, 1, 8'h3C, 1'b0);
      expectIdle(1'b0, 1, 400, "no_echo_ferr");
    join
    checkOutput("ferr1", 32'(ferr[15:8]), 32'd1);
    checkOutput("ferr0", 32'(ferr[7:0]), 32'd0);
    fork
      applyStimulus(1'b0, 1, 8'h3C, 1'b1);
      expectFrame(1'b0, 1, 8'h3C, "echo_3c");
    join

    txd[0] = 1'b0;
    repeat (5) @(negedge clock);
    txd[0] = 1'b1;
    expectIdle(1'b0, 0, 300, "glitch_no_echo");
    checkOutput("glitch_ferr0", 32'(ferr[7:0]), 32'd0);

    fork
      applyStimulus(1'b1, 0, 8'h5A, 1'b1);
      expectFrame(1'b1, 1, 8'h5A, "cross_5a");
      expectIdle(1'b1, 0, 400, "cross_rxd0_idle");
    join

    // Reset while channel 0 is transmitting the data bits of 0x00.
    fork
      applyStimulus(1'b0, 0, 8'h00, 1'b1);
      begin
        int waited;
        waited = 0;
        while (rxd[0] !== 1'b0 && waited < 2000) begin
          @(negedge clock);
          waited++;
        end
        repeat (BD + 40) @(negedge clock);
        checkOutput("rxd0_low_before_reset", 32'(rxd[0]), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midreset_rxd", 32'(rxd), 32'h3);
        checkOutput("midreset_cts", 32'(cts), 32'h0);
        checkOutput("midreset_ovr", 32'(ovr), 32'h0);
        checkOutput("midreset_ferr", 32'(ferr), 32'h0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("cts_after_midreset", 32'(cts), 32'h3);
      end
    join
    expectIdle(1'b0, 0, 400, "no_residual");
    checkOutput("dbr0_after_reset", dbr[31:0], 32'd16);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
